// File: rtl/control_pipe.sv
// Single-stage decode register for a MIPS-style front end: decodes one instruction per
// accept and inserts bubbles for multiply latency and load-use hazards.
module control_pipe #(
   parameter int unsigned MUL_LATENCY = 3,
   parameter bit          HAZARD_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [24:0] out_ctrl,
   output logic        out_illegal,
   output logic        mul_busy
);

   localparam int unsigned OP_W   = 6;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned FLAG_W = 10;

   localparam logic [OP_W-1:0] OP_JMP  = 6'd2;
   localparam logic [OP_W-1:0] OP_LW   = 6'd54;
   localparam logic [OP_W-1:0] OP_SW   = 6'd55;
   localparam logic [OP_W-1:0] OP_BNE  = 6'd56;
   localparam logic [OP_W-1:0] OP_ADDI = 6'd57;
   localparam logic [OP_W-1:0] OP_ORI  = 6'd58;

   localparam logic [OP_W-1:0] FN_ADD = 6'd32;
   localparam logic [OP_W-1:0] FN_SUB = 6'd34;
   localparam logic [OP_W-1:0] FN_AND = 6'd36;
   localparam logic [OP_W-1:0] FN_OR  = 6'd37;
   localparam logic [OP_W-1:0] FN_MUL = 6'd50;

   typedef struct packed {
      logic       wr_regfile;
      logic       sel_imm;
      logic [1:0] alu_sel;
      logic       mul_start;
      logic       sel_alu;
      logic       wr_mem;
      logic       wb_alu;
      logic       branch;
      logic       jmp;
   } flags_t;

   typedef struct packed {
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
      flags_t           f;
   } ctrl_t;

   // Flag order: wr_regfile, sel_imm, alu_sel, mul_start, sel_alu, wr_mem, wb_alu, branch, jmp
   localparam flags_t FL_JMP  = flags_t'(FLAG_W'(10'b0_0_00_0_1_0_0_0_1));
   localparam flags_t FL_LW   = flags_t'(FLAG_W'(10'b1_1_00_0_1_0_0_0_0));
   localparam flags_t FL_SW   = flags_t'(FLAG_W'(10'b0_1_00_0_1_1_0_0_0));
   localparam flags_t FL_BNE  = flags_t'(FLAG_W'(10'b0_0_01_0_1_0_0_1_0));
   localparam flags_t FL_ADDI = flags_t'(FLAG_W'(10'b1_1_00_0_1_0_1_0_0));
   localparam flags_t FL_ORI  = flags_t'(FLAG_W'(10'b1_1_11_0_1_0_1_0_0));
   localparam flags_t FL_ADD  = flags_t'(FLAG_W'(10'b1_0_00_0_1_0_1_0_0));
   localparam flags_t FL_SUB  = flags_t'(FLAG_W'(10'b1_0_01_0_1_0_1_0_0));
   localparam flags_t FL_AND  = flags_t'(FLAG_W'(10'b1_0_10_0_1_0_1_0_0));
   localparam flags_t FL_OR   = flags_t'(FLAG_W'(10'b1_0_11_0_1_0_1_0_0));
   localparam flags_t FL_MUL  = flags_t'(FLAG_W'(10'b1_0_00_1_0_0_1_0_0));

   logic [OP_W-1:0]  in_op;
   logic [OP_W-1:0]  in_funct;
   logic [REG_W-1:0] in_rs;
   logic [REG_W-1:0] in_rt;
   logic [REG_W-1:0] in_rd;
   logic             unused_shamt;

   assign in_op        = in_instr[31:26];
   assign in_rs        = in_instr[25:21];
   assign in_rt        = in_instr[20:16];
   assign in_rd        = in_instr[15:11];
   assign in_funct     = in_instr[5:0];
   assign unused_shamt = ^in_instr[10:6];

   // Registered state
   logic             out_valid_q, out_valid_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
   logic             lu_vld_q, lu_vld_d;
   logic [REG_W-1:0] lu_rd_q, lu_rd_d;

   // Decode
   flags_t           dec_flags;
   logic [REG_W-1:0] dec_rd;
   logic             dec_illegal;
   ctrl_t            dec_ctrl;
   logic             dec_is_lw;

   always_comb begin
      dec_flags   = '0;
      dec_rd      = in_rd;
      dec_illegal = 1'b0;
      case (in_op)
         OP_JMP:  begin dec_flags = FL_JMP;  dec_rd = '0;    end
         OP_LW:   begin dec_flags = FL_LW;   dec_rd = in_rt; end
         OP_SW:   begin dec_flags = FL_SW;   dec_rd = '0;    end
         OP_BNE:  begin dec_flags = FL_BNE;  dec_rd = '0;    end
         OP_ADDI: begin dec_flags = FL_ADDI; dec_rd = in_rt; end
         OP_ORI:  begin dec_flags = FL_ORI;  dec_rd = in_rt; end
         default: begin
            case (in_funct)
               FN_ADD:  dec_flags = FL_ADD;
               FN_SUB:  dec_flags = FL_SUB;
               FN_AND:  dec_flags = FL_AND;
               FN_OR:   dec_flags = FL_OR;
               FN_MUL:  dec_flags = FL_MUL;
               default: dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   // An undecodable instruction still occupies the output slot, but with an all-zero control word
   always_comb begin
      dec_ctrl = '0;
      if (!dec_illegal) begin
         dec_ctrl.rs = in_rs;
         dec_ctrl.rt = in_rt;
         dec_ctrl.rd = dec_rd;
         dec_ctrl.f  = dec_flags;
      end
   end

   assign dec_is_lw = (in_op == OP_LW);

   // Handshake and hazard detection
   logic lu_stall;
   logic accept;

   assign lu_stall = HAZARD_EN && lu_vld_q && in_valid &&
                     ((in_rs == lu_rd_q) || (in_rt == lu_rd_q));
   assign in_ready = !rst && !flush && (mul_cnt_q == '0) && !lu_stall &&
                     (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign mul_busy = (mul_cnt_q != '0);

   // Next state: flush > accept > drain; lu_vld lives for one cycle unless re-armed
   always_comb begin
      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      illegal_d   = illegal_q;
      mul_cnt_d   = mul_cnt_q;
      lu_vld_d    = 1'b0;
      lu_rd_d     = lu_rd_q;

      if (mul_cnt_q != '0) begin
         mul_cnt_d = mul_cnt_q - CNT_W'(1);
      end

      if (flush) begin
         out_valid_d = 1'b0;
         illegal_d   = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         ctrl_d      = dec_ctrl;
         illegal_d   = dec_illegal;
         if (dec_illegal) begin
            lu_vld_d = lu_vld_q;
         end else begin
            if (dec_flags.mul_start) begin
               mul_cnt_d = CNT_W'(MUL_LATENCY);
            end
            if (dec_is_lw && (in_rt != '0)) begin
               lu_vld_d = 1'b1;
               lu_rd_d  = in_rt;
            end
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         illegal_q   <= 1'b0;
         mul_cnt_q   <= '0;
         lu_vld_q    <= 1'b0;
         lu_rd_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         ctrl_q      <= ctrl_d;
         illegal_q   <= illegal_d;
         mul_cnt_q   <= mul_cnt_d;
         lu_vld_q    <= lu_vld_d;
         lu_rd_q     <= lu_rd_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_ctrl    = ctrl_q;
   assign out_illegal = illegal_q;

endmodule
